// File: rtl/paddle_input_ctrl.sv
// Per-player paddle command conditioner: button synchronise + debounce, up/down
// conflict resolution, demo (attract) oscillator, and tick-aligned step strobes.
module paddle_input_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEB_W           = 5,
  parameter int DEMO_HALF       = 64,
  parameter int DEMO_W          = 7
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   tick,
  input  logic [NUM_PLAYERS-1:0] btn_up,
  input  logic [NUM_PLAYERS-1:0] btn_down,
  input  logic [NUM_PLAYERS-1:0] demo_mode,
  output logic [NUM_PLAYERS-1:0] up_lvl,
  output logic [NUM_PLAYERS-1:0] down_lvl,
  output logic [NUM_PLAYERS-1:0] up_step,
  output logic [NUM_PLAYERS-1:0] down_step
);

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [1:0]        w_raw;
      logic [1:0]        w_deb;
      logic              w_man_up;
      logic              w_man_dn;
      logic [DEMO_W-1:0] r_demo_cnt;
      logic              r_phase;
      logic              r_up_lvl;
      logic              r_dn_lvl;
      logic              r_up_step;
      logic              r_dn_step;

      // bit 0 = up button, bit 1 = down button
      assign w_raw = {btn_down[gi], btn_up[gi]};

      for (gb = 0; gb < 2; gb++) begin : g_btn
        logic [1:0]       r_sync;
        logic             r_deb;
        logic [DEB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
          if (clr) begin
            r_sync <= '0;
            r_deb  <= 1'b0;
            r_cnt  <= '0;
          end else begin
            r_sync <= {r_sync[0], w_raw[gb]};
            // Any agreement with the debounced value restarts the count.
            if (r_sync[1] == r_deb) begin
              r_cnt <= '0;
            end else if (r_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
              r_deb <= r_sync[1];
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        assign w_deb[gb] = r_deb;
      end

      // Both pressed is treated the same as neither: no priority.
      assign w_man_up = w_deb[0] & ~w_deb[1];
      assign w_man_dn = w_deb[1] & ~w_deb[0];

      always_ff @(posedge clk) begin
        if (clr || !demo_mode[gi]) begin
          r_demo_cnt <= '0;
          r_phase    <= 1'b0;
        end else if (tick) begin
          if (r_demo_cnt == DEMO_W'(DEMO_HALF - 1)) begin
            r_demo_cnt <= '0;
            r_phase    <= ~r_phase;
          end else begin
            r_demo_cnt <= r_demo_cnt + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          r_up_lvl  <= 1'b0;
          r_dn_lvl  <= 1'b0;
          r_up_step <= 1'b0;
          r_dn_step <= 1'b0;
        end else begin
          r_up_lvl  <= demo_mode[gi] ? ~r_phase : w_man_up;
          r_dn_lvl  <= demo_mode[gi] ?  r_phase : w_man_dn;
          r_up_step <= tick & r_up_lvl;
          r_dn_step <= tick & r_dn_lvl;
        end
      end

      assign up_lvl[gi]    = r_up_lvl;
      assign down_lvl[gi]  = r_dn_lvl;
      assign up_step[gi]   = r_up_step;
      assign down_step[gi] = r_dn_step;
    end
  endgenerate

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl: directed scenarios plus randomized
// traffic compared against an event-level reference model.
module tb_paddle_input_ctrl;
  localparam int NP  = 2;
  localparam int DC  = 4;
  localparam int DW  = 3;
  localparam int DH  = 4;
  localparam int DMW = 2;

  logic          clk = 1'b0;
  logic          clr;
  logic          tick;
  logic [NP-1:0] btn_up, btn_down, demo_mode;
  logic [NP-1:0] up_lvl, down_lvl, up_step, down_step;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  paddle_input_ctrl #(
    .NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DC), .DEB_W(DW), .DEMO_HALF(DH), .DEMO_W(DMW)
  ) dut (
    .clk(clk), .clr(clr), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .demo_mode(demo_mode),
    .up_lvl(up_lvl), .down_lvl(down_lvl), .up_step(up_step), .down_step(down_step)
  );

  // Reference model: raw delayed two samples, debounced flips after DC consecutive
  // disagreeing samples, demo phase = (ticks since entering demo / DH) mod 2.
  logic          m_s1 [NP][2];
  logic          m_s2 [NP][2];
  logic          m_deb[NP][2];
  int            m_run[NP][2];
  int            m_ticks[NP];
  logic [NP-1:0] m_up, m_dn, m_us, m_ds;

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (clr) begin
        m_up[p] = 0; m_dn[p] = 0; m_us[p] = 0; m_ds[p] = 0; m_ticks[p] = 0;
        for (int b = 0; b < 2; b++) begin
          m_s1[p][b] = 0; m_s2[p][b] = 0; m_deb[p][b] = 0; m_run[p][b] = 0;
        end
      end else begin
        m_us[p] = tick & m_up[p];
        m_ds[p] = tick & m_dn[p];
        if (demo_mode[p]) begin
          m_up[p] = ((m_ticks[p] / DH) % 2) == 0;
          m_dn[p] = ((m_ticks[p] / DH) % 2) == 1;
        end else begin
          m_up[p] = m_deb[p][0] && !m_deb[p][1];
          m_dn[p] = m_deb[p][1] && !m_deb[p][0];
        end
        for (int b = 0; b < 2; b++) begin
          if (m_s2[p][b] != m_deb[p][b]) begin
            m_run[p][b]++;
            if (m_run[p][b] == DC) begin
              m_deb[p][b] = m_s2[p][b];
              m_run[p][b] = 0;
            end
          end else begin
            m_run[p][b] = 0;
          end
          m_s2[p][b] = m_s1[p][b];
          m_s1[p][b] = (b == 0) ? btn_up[p] : btn_down[p];
        end
        m_ticks[p] = demo_mode[p] ? m_ticks[p] + (tick ? 1 : 0) : 0;
      end
    end
  end

  function automatic logic [4*NP-1:0] mvec();
    return {m_up, m_dn, m_us, m_ds};
  endfunction

  function automatic logic [4*NP-1:0] dvec();
    return {up_lvl, down_lvl, up_step, down_step};
  endfunction

  task automatic do_reset();
    clr = 1'b1; tick = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    int rise;
    btn_up = '1; btn_down = '1; demo_mode = '0; tick = 1'b1; clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (dvec() !== '0) begin
        n_fail++; $display("FAIL reset_hold: got %b expected %b", dvec(), '0);
      end
    end
    clr = 1'b0; tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dvec() !== '0) begin
      n_fail++; $display("FAIL reset_release: got %b expected 0", dvec());
    end
    for (int k = 0; k < 12; k++) begin
      tick = k[0];
      @(negedge clk);
      n_checks++;
      if (dvec() !== mvec() || up_lvl !== '0) begin
        n_fail++; $display("FAIL reset_conflict: got %b expected %b", dvec(), mvec());
      end
    end
    tick = 1'b0; btn_down = '0;
    rise = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (up_lvl[0] && rise == 0) rise = k;
    end
    n_checks++;
    if (rise != 7) begin
      n_fail++; $display("FAIL reset_first_up: got edge %0d expected edge 7", rise);
    end
  endtask

  task automatic test_debounce();
    int rise, bad;
    btn_up = '0; btn_down = '0; demo_mode = '0;
    do_reset();
    btn_up[0] = 1'b1;
    rise = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (up_lvl[0] && rise == 0) rise = k;
    end
    n_checks++;
    if (rise != 7) begin
      n_fail++; $display("FAIL debounce_hold: got edge %0d expected edge 7", rise);
    end
    btn_up[0] = 1'b0;
    repeat (12) @(negedge clk);
    btn_up[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn_up[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (up_lvl[0] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL debounce_glitch: got %0d high cycles expected 0", bad);
    end
    btn_up[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn_up[0] = 1'b0;
    @(negedge clk);
    btn_up[0] = 1'b1;
    rise = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (up_lvl[0] && rise == 0) rise = k;
    end
    n_checks++;
    if (rise != 7) begin
      n_fail++; $display("FAIL debounce_restart: got edge %0d expected edge 7", rise);
    end
  endtask

  task automatic test_conflict();
    int bad, rise;
    btn_up = '0; btn_down = '0; demo_mode = '0;
    do_reset();
    btn_up[1] = 1'b1; btn_down[1] = 1'b1;
    repeat (12) @(negedge clk);
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick = 1'b1;
      @(negedge clk);
      if (up_lvl[1] | down_lvl[1] | up_step[1] | down_step[1]) bad++;
      tick = 1'b0;
      @(negedge clk);
      if (up_lvl[1] | down_lvl[1] | up_step[1] | down_step[1]) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL conflict_idle: got %0d active cycles expected 0", bad);
    end
    btn_down[1] = 1'b0;
    rise = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (up_lvl[1] && rise == 0) rise = k;
    end
    n_checks++;
    if (rise != 7) begin
      n_fail++; $display("FAIL conflict_release: got edge %0d expected edge 7", rise);
    end
  endtask

  task automatic test_steps();
    int on_time, late, dn;
    btn_up = '0; btn_down = '0; demo_mode = '0;
    do_reset();
    btn_up[0] = 1'b1;
    repeat (10) @(negedge clk);
    on_time = 0; late = 0; dn = 0;
    for (int t = 0; t < 6; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (up_step[0]) on_time++;
      if (down_step[0]) dn++;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (up_step[0]) late++;
        if (down_step[0]) dn++;
      end
    end
    n_checks++;
    if (on_time != 6) begin
      n_fail++; $display("FAIL steps_count: got %0d strobes expected 6", on_time);
    end
    n_checks++;
    if (late != 0) begin
      n_fail++; $display("FAIL steps_width: got %0d extra strobe cycles expected 0", late);
    end
    n_checks++;
    if (dn != 0) begin
      n_fail++; $display("FAIL steps_down: got %0d down strobes expected 0", dn);
    end
  endtask

  task automatic test_demo();
    logic [15:0] got_up, got_dn, exp_up;
    int bad;
    btn_up = '0; btn_down = '0; demo_mode = '0;
    do_reset();
    btn_down[1] = 1'b1;
    demo_mode[0] = 1'b1;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int t = 0; t < 16; t++) begin
      tick = 1'b1;
      btn_up[0] = 1'($urandom); btn_down[0] = 1'($urandom);
      @(negedge clk);
      tick = 1'b0;
      got_up[t] = up_step[0]; got_dn[t] = down_step[0];
      exp_up[t] = ((t / DH) % 2) == 0;
      if (dvec() !== mvec()) bad++;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if (dvec() !== mvec()) bad++;
      end
    end
    n_checks++;
    if (got_up !== exp_up) begin
      n_fail++; $display("FAIL demo_up_pattern: got %b expected %b", got_up, exp_up);
    end
    n_checks++;
    if (got_dn !== ~exp_up) begin
      n_fail++; $display("FAIL demo_down_pattern: got %b expected %b", got_dn, ~exp_up);
    end
    n_checks++;
    if (up_lvl[1] !== 1'b0 || down_lvl[1] !== 1'b1) begin
      n_fail++; $display("FAIL demo_player1: got up %b down %b expected up 0 down 1",
                         up_lvl[1], down_lvl[1]);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL demo_model: got %0d mismatching cycles expected 0", bad);
    end
    btn_up = '0; btn_down = '0;
  endtask

  task automatic test_demo_exit();
    logic [4:0] got_up, got_dn;
    btn_up = '0; btn_down = '0; demo_mode = '0;
    do_reset();
    demo_mode[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0; repeat (2) @(negedge clk);
    end
    demo_mode[0] = 1'b0;
    repeat (2) @(negedge clk);
    demo_mode[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      got_up[t] = up_step[0]; got_dn[t] = down_step[0];
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if ({got_up, got_dn} !== {5'b01111, 5'b10000}) begin
      n_fail++; $display("FAIL demo_reentry: got up %b down %b expected up 01111 down 10000",
                         got_up, got_dn);
    end
    tick = 1'b1; clr = 1'b1;
    @(negedge clk);
    tick = 1'b0; clr = 1'b0;
    n_checks++;
    if (dvec() !== '0) begin
      n_fail++; $display("FAIL demo_clr: got %b expected 0", dvec());
    end
    repeat (2) @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      got_up[t] = up_step[0]; got_dn[t] = down_step[0];
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if ({got_up, got_dn} !== {5'b01111, 5'b10000}) begin
      n_fail++; $display("FAIL demo_after_clr: got up %b down %b expected up 01111 down 10000",
                         got_up, got_dn);
    end
  endtask

  task automatic test_random();
    btn_up = '0; btn_down = '0; demo_mode = '0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 9) == 0)  btn_up[p]    = ~btn_up[p];
        if ($urandom_range(0, 9) == 0)  btn_down[p]  = ~btn_down[p];
        if ($urandom_range(0, 79) == 0) demo_mode[p] = ~demo_mode[p];
      end
      @(negedge clk);
      n_checks++;
      if (dvec() !== mvec() || (up_lvl & down_lvl) !== '0) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b expected %b", c, dvec(), mvec());
      end
    end
    clr = 1'b0; tick = 1'b0;
  endtask

  initial begin
    clr = 1'b1; tick = 1'b0;
    btn_up = '0; btn_down = '0; demo_mode = '0;
    @(negedge clk);
    test_reset();
    test_debounce();
    test_conflict();
    test_steps();
    test_demo();
    test_demo_exit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
